// File: rtl/sdram_responder.sv
// sdram_responder: cycle-accurate stand-in for a 16-bit SDR SDRAM behind the core's controller.
// Decodes commands, tracks banks and mode, serves bursts from an inferred RAM, latches the first protocol error.
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 8,
  parameter int TRCD     = 2
) (
  input  logic        clk,
  input  logic        init,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_ba,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic [12:0] mode_reg,
  output logic [15:0] refresh_cnt,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int ADDR_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int TW        = $clog2(TRCD + 2);

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_BST, CMD_PRE, CMD_REF, CMD_LMR
  } cmd_t;

  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} burst_state_t;

  cmd_t         cmd;
  logic         a10;
  logic [3:0]   open_vec;
  logic [3:0]   eff_open;
  logic [3:0]   close_mask_reg, close_mask_next;
  logic [ROW_BITS-1:0] row_arr [4];
  logic [TW-1:0]       trcd_arr [4];

  logic [12:0]  mode_word_reg;
  logic         mode_loaded_reg;
  logic [15:0]  refresh_reg;
  logic         err_reg;
  logic [2:0]   err_code_reg;

  logic         cl3;
  logic         wr_single;
  logic [2:0]   bl_mask;
  logic         bank_is_open, trcd_ok, bad_mode;
  logic         err_det, acc_ok, act_ok, lmr_ok;
  logic [2:0]   err_val;

  burst_state_t        burst_state_reg, burst_state_next;
  logic [1:0]          burst_bank_reg;
  logic [ROW_BITS-1:0] burst_row_reg;
  logic [COL_BITS-1:0] burst_col_reg;
  logic [2:0]          burst_beat_reg, burst_mask_reg;
  logic                burst_ap_reg;

  logic                truncate, clear_pipe;
  logic                acc_en, acc_write, acc_ap, acc_single, acc_last;
  logic [1:0]          acc_bank;
  logic [ROW_BITS-1:0] acc_row;
  logic [COL_BITS-1:0] acc_start, acc_col, mask_ext, beat_ext;
  logic [2:0]          acc_beat, acc_mask;
  logic [ADDR_BITS-1:0] acc_addr;

  logic [15:0] mem [DEPTH];
  logic [15:0] rd_data_reg;

  logic        v1_reg, cl3_1_reg, ap1_reg;
  logic [1:0]  bank1_reg;
  logic        v2_reg, ap2_reg;
  logic [1:0]  bank2_reg;
  logic [15:0] data2_reg;
  logic [15:0] dq_out_reg;
  logic        oe_reg;

  assign a10 = sd_addr[10];

  always_comb begin
    cmd = CMD_NOP;
    if (!sd_cs) begin
      case ({sd_ras, sd_cas, sd_we})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b110:  cmd = CMD_BST;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_LMR;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  // A bank whose auto-precharge lands on this edge already counts as idle.
  assign eff_open     = open_vec & ~close_mask_reg;
  assign bank_is_open = eff_open[sd_ba];
  assign trcd_ok      = trcd_arr[sd_ba] <= TW'(1);
  assign cl3          = mode_word_reg[6:4] == 3'd3;
  assign wr_single    = mode_word_reg[9];
  assign bad_mode     = ((sd_addr[6:4] != 3'd2) && (sd_addr[6:4] != 3'd3)) || sd_addr[2];

  always_comb begin
    case (mode_word_reg[1:0])
      2'd0:    bl_mask = 3'd0;
      2'd1:    bl_mask = 3'd1;
      2'd2:    bl_mask = 3'd3;
      default: bl_mask = 3'd7;
    endcase
  end

  always_comb begin
    err_det = 1'b0;
    err_val = 3'd0;
    acc_ok  = 1'b0;
    case (cmd)
      CMD_ACT: if (bank_is_open) begin err_det = 1'b1; err_val = 3'd1; end
      CMD_RD, CMD_WR: begin
        if (!bank_is_open)        begin err_det = 1'b1; err_val = 3'd2; end
        else if (!trcd_ok)        begin err_det = 1'b1; err_val = 3'd3; end
        else if (!mode_loaded_reg) begin err_det = 1'b1; err_val = 3'd7; end
        else acc_ok = 1'b1;
      end
      CMD_REF: if (|eff_open) begin err_det = 1'b1; err_val = 3'd4; end
      CMD_LMR: begin
        if (|eff_open)    begin err_det = 1'b1; err_val = 3'd5; end
        else if (bad_mode) begin err_det = 1'b1; err_val = 3'd6; end
      end
      default: ;
    endcase
  end

  assign act_ok = (cmd == CMD_ACT) && !bank_is_open;
  assign lmr_ok = (cmd == CMD_LMR) && !(|eff_open);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic                open_q;
      logic [ROW_BITS-1:0] row_q;
      logic [TW-1:0]       trcd_q;
      logic                pre_hit, act_hit;

      assign pre_hit = (cmd == CMD_PRE) && (a10 || (sd_ba == 2'(gi)));
      assign act_hit = act_ok && (sd_ba == 2'(gi));

      always_ff @(posedge clk) begin
        if (init) begin
          open_q <= 1'b0;
          row_q  <= '0;
          trcd_q <= '0;
        end else if (act_hit) begin
          open_q <= 1'b1;
          row_q  <= sd_addr[ROW_BITS-1:0];
          trcd_q <= TW'(TRCD);
        end else begin
          open_q <= eff_open[gi] & ~pre_hit;
          if (trcd_q != '0) trcd_q <= trcd_q - TW'(1);
        end
      end

      assign open_vec[gi] = open_q;
      assign row_arr[gi]  = row_q;
      assign trcd_arr[gi] = trcd_q;
    end
  endgenerate

  assign truncate   = acc_ok || (cmd == CMD_BST) ||
                      ((cmd == CMD_PRE) && (a10 || (sd_ba == burst_bank_reg)));
  assign clear_pipe = acc_ok && (cmd == CMD_WR);

  // Beat 0 comes straight from the command; later beats come from the burst registers.
  always_comb begin
    acc_en     = 1'b0;
    acc_write  = 1'b0;
    acc_bank   = burst_bank_reg;
    acc_row    = burst_row_reg;
    acc_start  = burst_col_reg;
    acc_beat   = burst_beat_reg;
    acc_mask   = burst_mask_reg;
    acc_ap     = burst_ap_reg;
    acc_single = 1'b0;
    if (acc_ok) begin
      acc_en     = 1'b1;
      acc_write  = (cmd == CMD_WR);
      acc_bank   = sd_ba;
      acc_row    = row_arr[sd_ba];
      acc_start  = sd_addr[COL_BITS-1:0];
      acc_beat   = 3'd0;
      acc_mask   = bl_mask;
      acc_ap     = a10;
      acc_single = (cmd == CMD_WR) && wr_single;
    end else if ((burst_state_reg != B_IDLE) && !truncate) begin
      acc_en    = 1'b1;
      acc_write = (burst_state_reg == B_WRITE);
    end
  end

  assign acc_last = acc_single || (acc_beat == acc_mask);
  assign mask_ext = COL_BITS'(acc_mask);
  assign beat_ext = COL_BITS'(acc_beat);
  assign acc_col  = (acc_start & ~mask_ext) | ((acc_start + beat_ext) & mask_ext);
  assign acc_addr = {acc_bank, acc_row, acc_col};

  always_comb begin
    burst_state_next = burst_state_reg;
    if (truncate) burst_state_next = B_IDLE;
    if (acc_en) begin
      if (acc_last)       burst_state_next = B_IDLE;
      else if (acc_write) burst_state_next = B_WRITE;
      else                burst_state_next = B_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (init) burst_state_reg <= B_IDLE;
    else      burst_state_reg <= burst_state_next;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      burst_bank_reg <= '0;
      burst_row_reg  <= '0;
      burst_col_reg  <= '0;
      burst_mask_reg <= '0;
      burst_ap_reg   <= 1'b0;
      burst_beat_reg <= '0;
    end else begin
      if (acc_ok) begin
        burst_bank_reg <= acc_bank;
        burst_row_reg  <= acc_row;
        burst_col_reg  <= acc_start;
        burst_mask_reg <= acc_mask;
        burst_ap_reg   <= acc_ap;
      end
      if (acc_en) burst_beat_reg <= acc_beat + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_en && acc_write) mem[acc_addr] <= sd_dq_in;
    rd_data_reg <= mem[acc_addr];
  end

  // CL2 beats leave from stage 1, CL3 beats take one extra register stage.
  always_ff @(posedge clk) begin
    if (init) begin
      v1_reg     <= 1'b0;
      cl3_1_reg  <= 1'b0;
      ap1_reg    <= 1'b0;
      bank1_reg  <= '0;
      v2_reg     <= 1'b0;
      ap2_reg    <= 1'b0;
      bank2_reg  <= '0;
      data2_reg  <= '0;
      dq_out_reg <= '0;
      oe_reg     <= 1'b0;
    end else begin
      v1_reg    <= acc_en && !acc_write;
      cl3_1_reg <= cl3;
      ap1_reg   <= acc_ap && acc_last;
      bank1_reg <= acc_bank;
      v2_reg    <= v1_reg && cl3_1_reg && !clear_pipe;
      ap2_reg   <= ap1_reg;
      bank2_reg <= bank1_reg;
      data2_reg <= rd_data_reg;
      if (v2_reg) begin
        dq_out_reg <= data2_reg;
        oe_reg     <= 1'b1;
      end else if (v1_reg && !cl3_1_reg) begin
        dq_out_reg <= rd_data_reg;
        oe_reg     <= 1'b1;
      end else begin
        dq_out_reg <= '0;
        oe_reg     <= 1'b0;
      end
    end
  end

  // Auto-precharge closes the bank on the edge after its final write beat or final read beat out.
  always_comb begin
    close_mask_next = '0;
    if (acc_en && acc_write && acc_last && acc_ap) close_mask_next[acc_bank] = 1'b1;
    if (v2_reg && ap2_reg)                         close_mask_next[bank2_reg] = 1'b1;
    else if (v1_reg && !cl3_1_reg && ap1_reg)      close_mask_next[bank1_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (init) close_mask_reg <= '0;
    else      close_mask_reg <= close_mask_next;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      mode_word_reg   <= '0;
      mode_loaded_reg <= 1'b0;
      refresh_reg     <= '0;
      err_reg         <= 1'b0;
      err_code_reg    <= '0;
    end else begin
      if (lmr_ok) begin
        mode_word_reg   <= sd_addr;
        mode_loaded_reg <= 1'b1;
      end
      if ((cmd == CMD_REF) && (refresh_reg != 16'hFFFF)) refresh_reg <= refresh_reg + 16'd1;
      if (err_det && !err_reg) begin
        err_reg      <= 1'b1;
        err_code_reg <= err_val;
      end
    end
  end

  assign sd_dq_out   = dq_out_reg;
  assign sd_dq_oe    = oe_reg;
  assign mode_reg    = mode_word_reg;
  assign refresh_cnt = refresh_reg;
  assign err         = err_reg;
  assign err_code    = err_code_reg;

endmodule
